id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and the combinational ALU.
- Captures the decoded instruction and three register-file operands.
- Resolves data hazards by forwarding from the EX and WB stages, and inserts a one-cycle bubble on load-use.
- Registered outputs drive the ALU inputs directly (rA_64bit_val, rB_64bit_val, Op_code, R_ins, WW).
- Instruction fields, MSB-first: Op_code [0:5], rD [6:10], rA [11:15], rB [16:20], PPP [21:23], WW [24:25], R_ins [26:31].

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/WB forwarding and load-use bubble
//
// Purpose:
//   Holds one decoded instruction and its three operands for the combinational
//   ALU. Operands are forwarded at capture from the instruction currently held
//   here (its ALU result) or from the WB stage. A load followed by a consumer of
//   its destination gets a single bubble, after which the loaded value arrives
//   through the WB path.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall_in           downstream hold: every stage register keeps its value
//   flush              squash the instruction being captured
//   id_instr, id_valid instruction word from IF/ID and its valid flag
//   rf_rA/rB/rD_data   register file reads for the rA, rB and rD fields
//   alu_result         ALU output for the instruction held in this stage
//   wb_en/addr/data    register file write port of the WB stage
//   ex_*               registered ALU operands and control fields
//   ex_valid           held instruction is real
//   hazard_stall       combinational load-use stall request for IF/ID
//
// Instruction word, bit 0 of the MSB-first field numbering is id_instr[31]:
//   Op_code [31:26]  rD [25:21]  rA [20:16]  rB [15:11]
//   PPP     [10:8]   WW [7:6]    R_ins [5:0]

module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] rf_rA_data,
    input  logic [DATA_W-1:0] rf_rB_data,
    input  logic [DATA_W-1:0] rf_rD_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] ex_rA_val,
    output logic [DATA_W-1:0] ex_rB_val,
    output logic [DATA_W-1:0] ex_rD_val,
    output logic [5:0]        ex_op_code,
    output logic [5:0]        ex_r_ins,
    output logic [1:0]        ex_ww,
    output logic [ADDR_W-1:0] ex_rD,
    output logic              ex_valid,
    output logic              hazard_stall
);

    localparam logic [5:0] OP_R_ALU     = 6'b101010;
    localparam logic [5:0] OP_LOAD      = 6'b100000;
    localparam logic [5:0] OP_STORE     = 6'b100001;
    localparam logic [5:0] OP_BRANCH_EZ = 6'b100010;
    localparam logic [5:0] OP_BRANCH_NZ = 6'b100011;
    localparam logic [5:0] OP_NOP       = 6'b111100;

    // ------------------------------------------------------------------
    // Incoming instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        id_op;
    logic [ADDR_W-1:0] id_rd;
    logic [ADDR_W-1:0] id_ra;
    logic [ADDR_W-1:0] id_rb;
    logic [1:0]        id_ww;
    logic [5:0]        id_r_ins;

    assign id_op    = id_instr[31:26];
    assign id_rd    = id_instr[25:21];
    assign id_ra    = id_instr[20:16];
    assign id_rb    = id_instr[15:11];
    assign id_ww    = id_instr[7:6];
    assign id_r_ins = id_instr[5:0];

    // PPP is decoded further down the pipe, not here.
    logic unused_ppp;
    assign unused_ppp = ^id_instr[10:8];

    // ------------------------------------------------------------------
    // Classification of the held instruction
    // ------------------------------------------------------------------
    logic held_writer;
    logic held_is_load;
    logic held_alu_fwd;
    logic held_load_writer;

    always_comb begin
        held_is_load = (ex_op_code == OP_LOAD);
        held_writer  = ex_valid && (ex_rD != '0) &&
                       (((ex_op_code == OP_R_ALU) && (ex_r_ins != 6'b000000)) ||
                        held_is_load);
        // A held LOAD has no value yet; only ALU writers can be bypassed.
        held_alu_fwd     = held_writer && !held_is_load;
        held_load_writer = held_writer && held_is_load;
    end

    // ------------------------------------------------------------------
    // Load-use detection against the source fields of the incoming opcode
    // ------------------------------------------------------------------
    logic src_match;

    always_comb begin
        src_match = 1'b0;
        case (id_op)
            OP_R_ALU:     src_match = (id_ra == ex_rD) || (id_rb == ex_rD);
            OP_STORE,
            OP_BRANCH_EZ,
            OP_BRANCH_NZ: src_match = (id_rd == ex_rD);
            default:      src_match = 1'b0;
        endcase
    end

    // flush/stall_in already prevent this capture, so no extra hold is needed.
    assign hazard_stall = id_valid && held_load_writer && src_match &&
                          !flush && !stall_in;

    // ------------------------------------------------------------------
    // Operand forwarding: R0 -> held ALU writer -> WB -> register file
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] rf_val,
        input logic              alu_ok,
        input logic [ADDR_W-1:0] held_rd,
        input logic [DATA_W-1:0] alu_val,
        input logic              wb_ok,
        input logic [ADDR_W-1:0] wb_idx,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] r;
        if (idx == '0)
            r = '0;
        else if (alu_ok && (held_rd == idx))
            r = alu_val;
        else if (wb_ok && (wb_idx == idx))
            r = wb_val;
        else
            r = rf_val;
        return r;
    endfunction

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] fwd_d;

    always_comb begin
        fwd_a = fwd_sel(id_ra, rf_rA_data, held_alu_fwd, ex_rD, alu_result,
                        wb_en, wb_addr, wb_data);
        fwd_b = fwd_sel(id_rb, rf_rB_data, held_alu_fwd, ex_rD, alu_result,
                        wb_en, wb_addr, wb_data);
        fwd_d = fwd_sel(id_rd, rf_rD_data, held_alu_fwd, ex_rD, alu_result,
                        wb_en, wb_addr, wb_data);
    end

    // ------------------------------------------------------------------
    // Stage register
    // Reset and bubble share one encoding: invalid NOP with zero fields.
    // flush beats stall_in, so a bubble can enter while downstream holds.
    // ------------------------------------------------------------------
    logic do_bubble;
    assign do_bubble = reset || flush || (!stall_in && hazard_stall);

    always_ff @(posedge clk) begin
        if (do_bubble) begin
            ex_valid   <= 1'b0;
            ex_op_code <= OP_NOP;
            ex_r_ins   <= '0;
            ex_ww      <= '0;
            ex_rD      <= '0;
            ex_rA_val  <= '0;
            ex_rB_val  <= '0;
            ex_rD_val  <= '0;
        end else if (!stall_in) begin
            ex_valid   <= id_valid;
            ex_op_code <= id_op;
            ex_r_ins   <= id_r_ins;
            ex_ww      <= id_ww;
            ex_rD      <= id_rd;
            ex_rA_val  <= fwd_a;
            ex_rB_val  <= fwd_b;
            ex_rD_val  <= fwd_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam logic [5:0] R_ALU = 6'b101010;
    localparam logic [5:0] LOAD  = 6'b100000;
    localparam logic [5:0] STORE = 6'b100001;
    localparam logic [5:0] BEZ   = 6'b100010;
    localparam logic [5:0] BNZ   = 6'b100011;
    localparam logic [5:0] NOP   = 6'b111100;

    logic        clk = 1'b0;
    logic        reset, stall_in, flush, id_valid, wb_en;
    logic [31:0] id_instr;
    logic [63:0] rf_rA_data, rf_rB_data, rf_rD_data, alu_result, wb_data;
    logic [4:0]  wb_addr;
    logic [63:0] ex_rA_val, ex_rB_val, ex_rD_val;
    logic [5:0]  ex_op_code, ex_r_ins;
    logic [1:0]  ex_ww;
    logic [4:0]  ex_rD;
    logic        ex_valid, hazard_stall;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush),
        .id_instr(id_instr), .id_valid(id_valid),
        .rf_rA_data(rf_rA_data), .rf_rB_data(rf_rB_data), .rf_rD_data(rf_rD_data),
        .alu_result(alu_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_rA_val(ex_rA_val), .ex_rB_val(ex_rB_val), .ex_rD_val(ex_rD_val),
        .ex_op_code(ex_op_code), .ex_r_ins(ex_r_ins), .ex_ww(ex_ww), .ex_rD(ex_rD),
        .ex_valid(ex_valid), .hazard_stall(hazard_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [2:0] ppp, input logic [1:0] ww,
                                        input logic [5:0] rins);
        return {op, rd, ra, rb, ppp, ww, rins};
    endfunction

    // Field by MSB-first bit positions [first:last].
    function automatic int unsigned fld(input logic [31:0] ins, input int first, input int last);
        int unsigned w;
        w = last - first + 1;
        return (ins >> (31 - last)) & ((1 << w) - 1);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: what instruction sits in EX, and what it carries
    // ------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic [5:0]  m_op = NOP, m_rins = '0;
    logic [1:0]  m_ww = '0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_a = '0, m_b = '0, m_d = '0;

    function automatic bit m_writes();
        if (!m_valid || m_rd == 0) return 0;
        if (m_op == LOAD) return 1;
        return (m_op == R_ALU) && (m_rins != 0);
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input int unsigned r);
        int unsigned op;
        op = fld(ins, 0, 5);
        if (op == R_ALU) return (fld(ins, 11, 15) == r) || (fld(ins, 16, 20) == r);
        if (op == STORE || op == BEZ || op == BNZ) return fld(ins, 6, 10) == r;
        return 0;
    endfunction

    function automatic bit exp_hz();
        return id_valid && !flush && !stall_in && m_writes() && (m_op == LOAD) &&
               reads_reg(id_instr, m_rd);
    endfunction

    function automatic logic [63:0] operand(input int unsigned idx, input logic [63:0] rf);
        if (idx == 0) return 64'd0;
        if (m_writes() && m_op != LOAD && m_rd == idx) return alu_result;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (reset || flush || (!stall_in && exp_hz())) begin
            m_valid <= 0; m_op <= NOP; m_rins <= 0; m_ww <= 0; m_rd <= 0;
            m_a <= 0; m_b <= 0; m_d <= 0;
        end else if (!stall_in) begin
            m_valid <= id_valid;
            m_op    <= 6'(fld(id_instr, 0, 5));
            m_rd    <= 5'(fld(id_instr, 6, 10));
            m_ww    <= 2'(fld(id_instr, 24, 25));
            m_rins  <= 6'(fld(id_instr, 26, 31));
            m_a     <= operand(fld(id_instr, 11, 15), rf_rA_data);
            m_b     <= operand(fld(id_instr, 16, 20), rf_rB_data);
            m_d     <= operand(fld(id_instr, 6, 10), rf_rD_data);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", {63'd0, ex_valid}, {63'd0, m_valid});
            chk("m_op", {58'd0, ex_op_code}, {58'd0, m_op});
            chk("m_rins", {58'd0, ex_r_ins}, {58'd0, m_rins});
            chk("m_ww", {62'd0, ex_ww}, {62'd0, m_ww});
            chk("m_rd", {59'd0, ex_rD}, {59'd0, m_rd});
            chk("m_a", ex_rA_val, m_a);
            chk("m_b", ex_rB_val, m_b);
            chk("m_d", ex_rD_val, m_d);
            chk("m_hazard", {63'd0, hazard_stall}, {63'd0, exp_hz()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall_in = 1; flush = 0; id_valid = 1; wb_en = 0; wb_addr = 0;
        id_instr = mk(R_ALU, 5'd3, 5'd1, 5'd2, 3'd0, 2'b10, 6'b000110);
        rf_rA_data = 64'h5; rf_rB_data = 64'h6; rf_rD_data = 64'h7;
        alu_result = 0; wb_data = 0;
        tick();
        cmp_en = 1;
        chk("reset_valid", {63'd0, ex_valid}, 64'd0);
        chk("reset_op", {58'd0, ex_op_code}, 64'h3C);
        chk("reset_rA", ex_rA_val, 64'd0);

        // VADD r3 = r1 + r2
        reset = 0; stall_in = 0;
        rf_rA_data = 64'h11; rf_rB_data = 64'h22; rf_rD_data = 64'h33;
        tick();
        chk("vadd_rA", ex_rA_val, 64'h11);
        chk("vadd_rB", ex_rB_val, 64'h22);
        chk("vadd_ww", {62'd0, ex_ww}, 64'd2);
        chk("vadd_rD", {59'd0, ex_rD}, 64'd3);
        chk("vadd_valid", {63'd0, ex_valid}, 64'd1);

        // VAND r4 = r3 & r1: EX result beats WB value
        id_instr = mk(R_ALU, 5'd4, 5'd3, 5'd1, 3'd0, 2'b01, 6'b000010);
        alu_result = 64'hDEAD; wb_en = 1; wb_addr = 3; wb_data = 64'hBEEF;
        rf_rA_data = 64'h55;
        tick();
        chk("fwd_ex_rA", ex_rA_val, 64'hDEAD);
        chk("fwd_ex_rB", ex_rB_val, 64'h22);

        // LOAD r5, then VOR r6 = r1 | r5 -> one bubble
        id_instr = {LOAD, 5'd5, 5'd0, 16'h0012}; wb_en = 0;
        tick();
        chk("load_op", {58'd0, ex_op_code}, 64'h20);
        id_instr = mk(R_ALU, 5'd6, 5'd1, 5'd5, 3'd0, 2'b11, 6'b000011);
        rf_rB_data = 64'h99;
        #1 chk("lu_hazard_on", {63'd0, hazard_stall}, 64'd1);
        tick();
        chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        chk("lu_bubble_op", {58'd0, ex_op_code}, 64'h3C);
        chk("lu_hazard_off", {63'd0, hazard_stall}, 64'd0);
        wb_en = 1; wb_addr = 5; wb_data = 64'h77;
        tick();
        chk("lu_wb_rB", ex_rB_val, 64'h77);
        chk("lu_valid", {63'd0, ex_valid}, 64'd1);

        // R0 is never forwarded
        wb_en = 0;
        id_instr = mk(R_ALU, 5'd0, 5'd1, 5'd2, 3'd0, 2'b00, 6'b000001);
        tick();
        id_instr = mk(R_ALU, 5'd7, 5'd0, 5'd2, 3'd0, 2'b00, 6'b000110);
        rf_rA_data = 64'hFF; alu_result = 64'h1234; wb_en = 1; wb_addr = 0; wb_data = 64'h99;
        tick();
        chk("r0_rA", ex_rA_val, 64'd0);
        id_instr = {LOAD, 5'd0, 5'd0, 16'h0005};
        tick();
        id_instr = mk(R_ALU, 5'd8, 5'd0, 5'd0, 3'd0, 2'b00, 6'b000110);
        #1 chk("r0_no_hazard", {63'd0, hazard_stall}, 64'd0);
        tick();

        // flush + stall_in together, then stall_in alone holds the bubble
        wb_en = 0;
        id_instr = mk(R_ALU, 5'd9, 5'd1, 5'd2, 3'd0, 2'b10, 6'b000110);
        rf_rA_data = 64'h1111;
        tick();
        flush = 1; stall_in = 1;
        id_instr = mk(R_ALU, 5'd11, 5'd1, 5'd2, 3'd0, 2'b10, 6'b000110);
        tick();
        chk("flush_stall_valid", {63'd0, ex_valid}, 64'd0);
        flush = 0;
        for (int i = 0; i < 3; i++) begin
            rf_rA_data = 64'(i + 100);
            tick();
            chk("stall_bubble_valid", {63'd0, ex_valid}, 64'd0);
        end

        // stall_in holds a valid instruction for 3 cycles
        stall_in = 0;
        id_instr = mk(R_ALU, 5'd10, 5'd1, 5'd2, 3'd0, 2'b01, 6'b000101);
        rf_rA_data = 64'hAAAA;
        tick();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            rf_rA_data = 64'(i + 7);
            id_instr = mk(STORE, 5'(i + 12), 5'd1, 5'd2, 3'd0, 2'b00, 6'b000000);
            tick();
            chk("stall_hold_rA", ex_rA_val, 64'hAAAA);
            chk("stall_hold_rD", {59'd0, ex_rD}, 64'd10);
            chk("stall_hold_valid", {63'd0, ex_valid}, 64'd1);
        end

        // hazard masked by stall_in; reset during a load-use stall
        stall_in = 0;
        id_instr = {LOAD, 5'd5, 5'd0, 16'h0003};
        tick();
        id_instr = mk(STORE, 5'd5, 5'd1, 5'd2, 3'd0, 2'b00, 6'b000000);
        stall_in = 1;
        #1 chk("hz_masked_stall", {63'd0, hazard_stall}, 64'd0);
        stall_in = 0;
        #1 chk("hz_store_rd", {63'd0, hazard_stall}, 64'd1);
        reset = 1;
        tick();
        reset = 0;
        #1 chk("hz_after_reset", {63'd0, hazard_stall}, 64'd0);

        // hazard masked by flush
        id_instr = {LOAD, 5'd5, 5'd0, 16'h0003};
        tick();
        id_instr = mk(BNZ, 5'd5, 5'd0, 5'd0, 3'd0, 2'b00, 6'b000000);
        flush = 1;
        #1 chk("hz_masked_flush", {63'd0, hazard_stall}, 64'd0);
        tick();
        flush = 0;

        // id_valid=0 still loads fields but marks the slot invalid
        id_valid = 0;
        id_instr = mk(STORE, 5'd2, 5'd1, 5'd1, 3'd0, 2'b00, 6'b000000);
        tick();
        chk("invalid_valid", {63'd0, ex_valid}, 64'd0);
        chk("invalid_op", {58'd0, ex_op_code}, 64'h21);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ops [7];
            ops = '{R_ALU, LOAD, STORE, BEZ, BNZ, NOP, 6'b000111};
            id_instr = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          3'($urandom), 2'($urandom), 6'($urandom_range(0, 2)));
            id_valid   = ($urandom_range(0, 7) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            stall_in   = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 39) == 0);
            wb_en      = $urandom_range(0, 1);
            wb_addr    = 5'($urandom_range(0, 3));
            wb_data    = {$urandom, $urandom};
            alu_result = {$urandom, $urandom};
            rf_rA_data = {$urandom, $urandom};
            rf_rB_data = {$urandom, $urandom};
            rf_rD_data = {$urandom, $urandom};
            tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
